// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access sizes, FSM states
// and the alignment rule.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_t;

  // size=11 is never legal; half needs an even address, word a 4-byte one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lane[0];
      SIZE_WORD: mis = (lane != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian word: extracts and extends load
// data, and merges sub-word store data into the word read back from RAM.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[{lane, 3'b000} +: 8];
    half_sel   = word[{lane[1], 4'b0000} +: 16];
    load_data  = word;
    store_word = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data  = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
        store_word = word;
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data  = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
        store_word = word;
        store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of ram_datos: byte-addressed requests become
// RAM read, write or read-modify-write cycles with a one-cycle completion pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_wea,
  output logic              ram_ena,
  input  logic [DATA_W-1:0] ram_douta
);

  state_t state_q, state_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              err_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wbuf_q;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;
  logic              req_mis;

  assign req_mis = is_misaligned(req_size, req_addr[1:0]);

  // wbuf_q doubles as the captured store data until the RD cycle merges into it.
  mem_lane_align u_align (
    .word        (ram_douta),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wbuf_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clka) begin
    if (!rsta_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_mis)                              state_d = ST_RESP;
          else if (req_we && req_size == SIZE_WORD) state_d = ST_WR;
          else                                      state_d = ST_RD;
        end
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_IDLE;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE) && rsta_n;
    ram_ena   = (state_q == ST_RD);
    ram_wea   = (state_q == ST_WR);
    ram_dina  = (state_q == ST_WR) ? wbuf_q : '0;
    ram_addra = addr_q[ADDR_W+1:2];
    rsp_valid = (state_q == ST_WR) || (state_q == ST_RESP);
    rsp_err   = (state_q == ST_RESP) && err_q;
    rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      wbuf_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            err_q   <= req_mis;
            addr_q  <= req_addr;
            rdata_q <= '0;
            wbuf_q  <= req_wdata;
          end
        end
        ST_RD: begin
          if (we_q) wbuf_q  <= store_word;
          else      rdata_q <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural ram_datos stand-in
// (BRAM[i] = i+128) and a cycle-indexed reference model of the expected traffic.
module tb_mem_access_unit;

  logic        clka = 1'b0;
  logic        rsta_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  ram_addra;
  logic [31:0] ram_dina;
  logic        ram_wea;
  logic        ram_ena;
  logic [31:0] ram_douta;

  mem_access_unit #(.DATA_W(32), .ADDR_W(10)) dut (
    .clka         (clka),
    .rsta_n       (rsta_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .ram_addra    (ram_addra),
    .ram_dina     (ram_dina),
    .ram_wea      (ram_wea),
    .ram_ena      (ram_ena),
    .ram_douta    (ram_douta)
  );

  always #5 clka = ~clka;

  // RAM stand-in: low-latency port sampling on the falling edge.
  logic [31:0] bram [1024];
  always @(negedge clka) begin
    if (ram_wea) bram[ram_addra] <= ram_dina;
    if (ram_ena) ram_douta <= bram[ram_addra];
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory image plus the RAM/response events expected per cycle.
  logic [31:0] ref_mem [1024];
  logic [9:0]  exp_ena_addr [int];
  logic [9:0]  exp_wea_addr [int];
  logic [31:0] exp_wea_data [int];
  logic        exp_rsp_err  [int];
  logic [31:0] exp_rsp_data [int];

  bit          chk_en = 1'b0;
  int          last_rsp_cyc;
  logic        last_err;
  logic [31:0] last_rdata;

  always @(negedge clka) begin
    if (chk_en) begin
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp_err.exists(cyc)});
      if (exp_rsp_err.exists(cyc) && rsp_valid) begin
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_rsp_err[cyc]});
        chk("rsp_rdata", rsp_rdata, exp_rsp_data[cyc]);
        last_rsp_cyc = cyc;
        last_err     = rsp_err;
        last_rdata   = rsp_rdata;
      end
      chk("ram_ena", {31'b0, ram_ena}, {31'b0, exp_ena_addr.exists(cyc)});
      if (exp_ena_addr.exists(cyc))
        chk("ena_addra", {22'b0, ram_addra}, {22'b0, exp_ena_addr[cyc]});
      chk("ram_wea", {31'b0, ram_wea}, {31'b0, exp_wea_addr.exists(cyc)});
      if (exp_wea_addr.exists(cyc)) begin
        chk("wea_addra", {22'b0, ram_addra}, {22'b0, exp_wea_addr[cyc]});
        chk("wea_dina", ram_dina, exp_wea_data[cyc]);
      end
      chk("ena_wea_excl", {31'b0, ram_ena & ram_wea}, 32'd0);
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input bit abort, output int acc);
    int          waits;
    int          wi;
    int          sh;
    bit          mis;
    logic [31:0] w, v, m;
    waits = 0;
    @(negedge clka);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready) begin
      if (waits > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        acc = -1;
        return;
      end
      @(negedge clka);
      waits++;
    end
    acc = cyc + 1;
    last_rsp_cyc = -100;
    wi  = int'(addr[11:2]);
    sh  = 8 * int'(addr[1:0]);
    mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    w   = ref_mem[wi];
    if (abort) begin
      if (!mis) exp_ena_addr[acc] = wi[9:0];
    end else if (mis) begin
      exp_rsp_err[acc] = 1'b1; exp_rsp_data[acc] = 32'd0;
    end else if (!we) begin
      if (size == 2'b00) begin
        v = (w >> sh) & 32'hFF;
        if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
        v = (w >> sh) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      exp_ena_addr[acc] = wi[9:0];
      exp_rsp_err[acc+1] = 1'b0; exp_rsp_data[acc+1] = v;
    end else if (size == 2'b10) begin
      exp_wea_addr[acc] = wi[9:0]; exp_wea_data[acc] = wdata;
      exp_rsp_err[acc] = 1'b0; exp_rsp_data[acc] = 32'd0;
      ref_mem[wi] = wdata;
    end else begin
      m = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      v = (w & ~m) | ((wdata << sh) & m);
      exp_ena_addr[acc] = wi[9:0];
      exp_wea_addr[acc+1] = wi[9:0]; exp_wea_data[acc+1] = v;
      exp_rsp_err[acc+1] = 1'b0; exp_rsp_data[acc+1] = 32'd0;
      ref_mem[wi] = v;
    end
    @(posedge clka);
    #1 req_valid = 1'b0;
    if (abort) begin
      @(negedge clka);
      rsta_n = 1'b0;
      @(negedge clka);
      rsta_n = 1'b1;
    end
    repeat (3) @(negedge clka);
  endtask

  task automatic load_lit(input string name, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] exp);
    int a;
    do_req(1'b0, size, uns, addr, 32'd0, 1'b0, a);
    chk({name, "_data"}, last_rdata, exp);
    chk({name, "_latency"}, last_rsp_cyc - a, 32'd1);
  endtask

  task automatic err_lit(input string name, input logic we, input logic [1:0] size,
                         input logic [11:0] addr);
    int a;
    do_req(we, size, 1'b0, addr, 32'hFFFF_FFFF, 1'b0, a);
    chk({name, "_err"}, {31'b0, last_err}, 32'd1);
    chk({name, "_rdata"}, last_rdata, 32'd0);
    chk({name, "_latency"}, last_rsp_cyc - a, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    for (int i = 0; i < 1024; i++) begin
      bram[i]    = 32'(i + 128);
      ref_mem[i] = 32'(i + 128);
    end
    ram_douta = '0;
    rsta_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 12'h010; req_wdata = '0;

    // Held in reset with a request pending.
    @(posedge clka);
    #1 chk_en = 1'b1;
    repeat (3) begin
      @(negedge clka);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_dina", ram_dina, 32'd0);
      chk("rst_addra", {22'b0, ram_addra}, 32'd0);
    end
    rsta_n = 1'b1;
    req_valid = 1'b0;
    #1 chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    load_lit("lw_010",  2'b10, 1'b0, 12'h010, 32'h0000_0084);
    load_lit("lb_010",  2'b00, 1'b0, 12'h010, 32'hFFFF_FF84);
    load_lit("lbu_010", 2'b00, 1'b1, 12'h010, 32'h0000_0084);
    load_lit("lh_012",  2'b01, 1'b0, 12'h012, 32'h0000_0000);
    load_lit("lhu_014", 2'b01, 1'b1, 12'h014, 32'h0000_0085);

    do_req(1'b1, 2'b00, 1'b0, 12'h011, 32'h0000_00AB, 1'b0, a);
    chk("sb_011_latency", last_rsp_cyc - a, 32'd1);
    chk("sb_011_ram", bram[4], 32'h0000_AB84);
    load_lit("lw_after_sb", 2'b10, 1'b0, 12'h010, 32'h0000_AB84);
    load_lit("lb_011", 2'b00, 1'b0, 12'h011, 32'hFFFF_FFAB);

    do_req(1'b1, 2'b01, 1'b0, 12'h016, 32'h0000_1234, 1'b0, a);
    chk("sh_016_ram", bram[5], 32'h1234_0085);
    load_lit("lw_after_sh", 2'b10, 1'b0, 12'h014, 32'h1234_0085);
    load_lit("lh_016", 2'b01, 1'b0, 12'h016, 32'h0000_1234);

    do_req(1'b1, 2'b10, 1'b0, 12'h018, 32'hDEAD_BEEF, 1'b0, a);
    chk("sw_018_latency", last_rsp_cyc - a, 32'd0);
    load_lit("lw_after_sw", 2'b10, 1'b0, 12'h018, 32'hDEAD_BEEF);
    load_lit("lh_01a", 2'b01, 1'b0, 12'h01A, 32'hFFFF_DEAD);
    load_lit("lbu_01b", 2'b00, 1'b1, 12'h01B, 32'h0000_00DE);

    err_lit("lw_012", 1'b0, 2'b10, 12'h012);
    err_lit("sh_013", 1'b1, 2'b01, 12'h013);
    err_lit("size11", 1'b0, 2'b11, 12'h000);
    chk("err_no_write", bram[4], 32'h0000_AB84);

    // SB interrupted by reset at the edge closing its read cycle.
    do_req(1'b1, 2'b00, 1'b0, 12'h021, 32'h0000_00FF, 1'b1, a);
    chk("abort_ram", bram[8], 32'h0000_0088);
    load_lit("lw_after_abort", 2'b10, 1'b0, 12'h020, 32'h0000_0088);

    // Top of the address space.
    load_lit("lw_top", 2'b10, 1'b0, 12'hFFC, 32'h0000_047F);
    do_req(1'b1, 2'b00, 1'b0, 12'hFFF, 32'h0000_0099, 1'b0, a);
    load_lit("lw_top_sb", 2'b10, 1'b0, 12'hFFC, 32'h9900_047F);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
